// File: rtl/jtframe_sdram64_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_sdram64_arb_if
// Description : Bundle of the SDRAM command-bus arbiter signals. It carries
//               the refresh and per-bank request/grant lines, the requester
//               cmd/address buses, and the registered SDRAM pins.
//               Optional macro JTFRAME_SDRAM64_ARB_CHECK_EN adds bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_sdram64_arb_if #(
    parameter int AW = 13
);
    logic            rfsh_br;
    logic            rfsh_bg;
    logic            rfshing;
    logic [3:0]      rfsh_cmd;
    logic [AW-1:0]   rfsh_a;
    logic [3:0]      bank_br;
    logic [3:0]      bank_bg;
    logic [3:0]      bank_busy;
    logic [15:0]     bank_cmd;
    logic [4*AW-1:0] bank_a;
    logic [3:0]      sdram_cmd;
    logic [AW-1:0]   sdram_a;
    logic [1:0]      sdram_ba;
`ifdef JTFRAME_SDRAM64_ARB_CHECK_EN
    logic            bus_err;

    // Arbiter side
    modport slave (
        input  rfsh_br, rfshing, rfsh_cmd, rfsh_a,
        input  bank_br, bank_busy, bank_cmd, bank_a,
        output rfsh_bg, bank_bg, sdram_cmd, sdram_a, sdram_ba, bus_err
    );

    // Requester / pin-consumer side
    modport master (
        output rfsh_br, rfshing, rfsh_cmd, rfsh_a,
        output bank_br, bank_busy, bank_cmd, bank_a,
        input  rfsh_bg, bank_bg, sdram_cmd, sdram_a, sdram_ba, bus_err
    );
`else
    // Arbiter side
    modport slave (
        input  rfsh_br, rfshing, rfsh_cmd, rfsh_a,
        input  bank_br, bank_busy, bank_cmd, bank_a,
        output rfsh_bg, bank_bg, sdram_cmd, sdram_a, sdram_ba
    );

    // Requester / pin-consumer side
    modport master (
        output rfsh_br, rfshing, rfsh_cmd, rfsh_a,
        output bank_br, bank_busy, bank_cmd, bank_a,
        input  rfsh_bg, bank_bg, sdram_cmd, sdram_a, sdram_ba
    );
`endif
endinterface
`default_nettype wire

// File: rtl/jtframe_sdram64_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_sdram64_arb
// Description : SDRAM command-bus arbiter. Grants the bus to the refresh
//               generator (priority, only once all banks are idle) or to one
//               of four bank controllers in round-robin order, and muxes the
//               owner's cmd/address onto registered SDRAM pins.
//               Optional macro JTFRAME_SDRAM64_ARB_CHECK_EN adds a sticky
//               bus_err flag for non-owners driving non-NOP commands.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_sdram64_arb #(
    parameter int HF = 1,
    parameter int AW = 13
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    jtframe_sdram64_arb_if.slave  bus
);

    localparam logic [3:0] c_NOP = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BANK = 2'd1,
        ST_RFSH = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [1:0]    owner_q;
    logic [1:0]    ptr_q;
    logic          seen_q;     // rfshing has been high during this RFSH visit
    logic [3:0]    sdram_cmd_q;
    logic [AW-1:0] sdram_a_q;
    logic [1:0]    sdram_ba_q;

    // Per-bank views of the flattened cmd/address buses
    logic [3:0]    w_bank_cmd [4];
    logic [AW-1:0] w_bank_a   [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_split
        assign w_bank_cmd[gi] = bus.bank_cmd[4*gi +: 4];
        assign w_bank_a[gi]   = bus.bank_a[AW*gi +: AW];
    end

    logic [1:0] w_rr_idx;
    logic       w_rr_hit;
    logic       w_idle;
    logic       w_rfsh_gnt;
    logic       w_bank_gnt;

    // Round-robin search: walk from the farthest candidate back to ptr_q so
    // the request nearest the pointer wins.
    always_comb begin
        w_rr_idx = ptr_q;
        w_rr_hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.bank_br[ptr_q + 2'(k)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = ptr_q + 2'(k);
            end
        end
    end

    // Grants are only issued from IDLE and never while reset is applied.
    // A pending refresh request blocks bank grants so the banks drain.
    assign w_idle     = (state_q == ST_IDLE) && rst_n;
    assign w_rfsh_gnt = w_idle && bus.rfsh_br && (bus.bank_busy == 4'b0000);
    assign w_bank_gnt = w_idle && !bus.rfsh_br && w_rr_hit;

    assign bus.rfsh_bg   = w_rfsh_gnt;
    assign bus.bank_bg   = w_bank_gnt ? (4'b0001 << w_rr_idx) : 4'b0000;
    assign bus.sdram_cmd = sdram_cmd_q;
    assign bus.sdram_a   = sdram_a_q;
    assign bus.sdram_ba  = sdram_ba_q;

    // Ownership FSM plus the registered pin mux driven by the current owner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd0;
            seen_q      <= 1'b0;
            sdram_cmd_q <= c_NOP;
            sdram_a_q   <= '0;
            sdram_ba_q  <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_rfsh_gnt) begin
                        state_q <= ST_RFSH;
                        seen_q  <= 1'b0;
                    end else if (w_bank_gnt) begin
                        state_q <= ST_BANK;
                        owner_q <= w_rr_idx;
                        ptr_q   <= w_rr_idx + 2'd1;
                    end
                end
                ST_BANK: begin
                    state_q <= (HF != 0) ? ST_GAP : ST_IDLE;
                end
                ST_RFSH: begin
                    // Leave only on a falling rfshing, not on a late start
                    if (bus.rfshing) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            case (state_q)
                ST_RFSH: begin
                    sdram_cmd_q <= bus.rfsh_cmd;
                    sdram_a_q   <= bus.rfsh_a;
                    sdram_ba_q  <= 2'd0;
                end
                ST_BANK: begin
                    sdram_cmd_q <= w_bank_cmd[owner_q];
                    sdram_a_q   <= w_bank_a[owner_q];
                    sdram_ba_q  <= owner_q;
                end
                default: begin
                    sdram_cmd_q <= c_NOP;
                end
            endcase
        end
    end

`ifdef JTFRAME_SDRAM64_ARB_CHECK_EN
    logic bus_err_q;
    logic w_err;

    // Any requester that is not the current owner must hold NOP
    always_comb begin
        w_err = (state_q != ST_RFSH) && (bus.rfsh_cmd != c_NOP);
        for (int j = 0; j < 4; j++) begin
            if ((w_bank_cmd[j] != c_NOP) &&
                !((state_q == ST_BANK) && (owner_q == 2'(j)))) begin
                w_err = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else if (w_err) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus.bus_err = bus_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdram64_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_sdram64_arb
// Description : Self-checking bench for jtframe_sdram64_arb (HF=1, AW=13).
//               Table of per-cycle vectors with same-cycle grant checks and a
//               scoreboard for the one-cycle-late SDRAM pins, followed by
//               hand-written refresh-wait and bus_err sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_sdram64_arb;

    localparam int         AW  = 13;
    localparam logic [3:0] NOP = 4'b0111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    jtframe_sdram64_arb_if #(.AW(AW)) bus ();

    jtframe_sdram64_arb #(.HF(1), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          rn;
        logic          rbr;
        logic          rfg;
        logic [3:0]    rcmd;
        logic [3:0]    bbr;
        logic [3:0]    busy;
        int            drv;     // bank driving bcmd/aval, 4 = none
        logic [3:0]    bcmd;
        logic [AW-1:0] aval;
        logic          e_rbg;
        logic [3:0]    e_bbg;
        logic [3:0]    e_cmd;   // pins expected one cycle later
        logic [AW-1:0] e_a;
        logic [1:0]    e_ba;
    } vec_t;

    typedef struct {
        logic [3:0]    cmd;
        logic [AW-1:0] a;
        logic [1:0]    ba;
    } pins_t;

    vec_t  vecs[$];
    pins_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic rbr, input logic rfg,
                       input logic [3:0] rcmd, input logic [3:0] bbr,
                       input logic [3:0] busy, input int drv,
                       input logic [3:0] bcmd, input logic [AW-1:0] aval,
                       input logic e_rbg, input logic [3:0] e_bbg,
                       input logic [3:0] e_cmd, input logic [AW-1:0] e_a,
                       input logic [1:0] e_ba);
        vec_t v;
        v.rn = rn; v.rbr = rbr; v.rfg = rfg; v.rcmd = rcmd; v.bbr = bbr;
        v.busy = busy; v.drv = drv; v.bcmd = bcmd; v.aval = aval;
        v.e_rbg = e_rbg; v.e_bbg = e_bbg; v.e_cmd = e_cmd; v.e_a = e_a; v.e_ba = e_ba;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        logic [15:0]     cmds;
        logic [4*AW-1:0] addrs;
        for (int j = 0; j < 4; j++) begin
            if (v.drv == j) begin
                cmds[4*j +: 4]    = v.bcmd;
                addrs[AW*j +: AW] = v.aval;
            end else begin
                cmds[4*j +: 4]    = NOP;
                addrs[AW*j +: AW] = AW'(13'h0A0 + j);
            end
        end
        rst_n         = v.rn;
        bus.rfsh_br   = v.rbr;
        bus.rfshing   = v.rfg;
        bus.rfsh_cmd  = v.rcmd;
        bus.rfsh_a    = v.aval;
        bus.bank_br   = v.bbr;
        bus.bank_busy = v.busy;
        bus.bank_cmd  = cmds;
        bus.bank_a    = addrs;
    endtask

    task automatic idle_vec(output vec_t v);
        v.rn = 1'b1; v.rbr = 1'b0; v.rfg = 1'b0; v.rcmd = NOP; v.bbr = 4'h0;
        v.busy = 4'h0; v.drv = 4; v.bcmd = NOP; v.aval = '0;
        v.e_rbg = 1'b0; v.e_bbg = 4'h0; v.e_cmd = NOP; v.e_a = '0; v.e_ba = 2'd0;
    endtask

    // Global time limit
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t  v;
        pins_t p;
        bit    got;

        idle_vec(v);
        v.rn = 1'b0;
        drive(v);

        // Reset with every request high
        for (int i = 0; i < 3; i++)
            add(0,1,0,NOP,4'hF,4'h0,4,NOP,'0,        0,4'b0000, NOP,'0,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,'0,2'd0);
        // Single bank 2 access
        add(1,0,0,NOP,4'b0100,4'h0,4,NOP,'0,         0,4'b0100, NOP,'0,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,2,4'b0011,13'h123,   0,4'b0000, 4'b0011,13'h123,2'd2);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h123,2'd2);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h123,2'd2);
        // Reset to bring the round-robin pointer back to 0
        add(0,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,'0,2'd0);
        // Round robin with all banks requesting
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0001, NOP,'0,2'd0);
        add(1,0,0,NOP,4'hF,4'h0,0,4'b0100,13'h010,   0,4'b0000, 4'b0100,13'h010,2'd0);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h010,2'd0);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0010, NOP,13'h010,2'd0);
        add(1,0,0,NOP,4'hF,4'h0,1,4'b0101,13'h011,   0,4'b0000, 4'b0101,13'h011,2'd1);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h011,2'd1);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0100, NOP,13'h011,2'd1);
        add(1,0,0,NOP,4'hF,4'h0,2,4'b0100,13'h012,   0,4'b0000, 4'b0100,13'h012,2'd2);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h012,2'd2);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b1000, NOP,13'h012,2'd2);
        add(1,0,0,NOP,4'hF,4'h0,3,4'b0101,13'h013,   0,4'b0000, 4'b0101,13'h013,2'd3);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h013,2'd3);
        add(1,0,0,NOP,4'hF,4'h0,4,NOP,'0,            0,4'b0001, NOP,13'h013,2'd3);
        add(1,0,0,NOP,4'h0,4'h0,0,4'b0011,13'h020,   0,4'b0000, 4'b0011,13'h020,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h020,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h020,2'd0);
        // Refresh waits for busy bank, then owns the bus for 10 cycles
        add(1,1,0,NOP,4'b0001,4'b0010,4,NOP,'0,      0,4'b0000, NOP,13'h020,2'd0);
        add(1,1,0,NOP,4'b0001,4'b0010,4,NOP,'0,      0,4'b0000, NOP,13'h020,2'd0);
        add(1,1,0,NOP,4'b0001,4'h0,4,NOP,'0,         1,4'b0000, NOP,13'h020,2'd0);
        for (int i = 0; i < 5; i++)
            add(1,0,1,4'b0010,4'b0001,4'h0,4,NOP,13'h400, 0,4'b0000, 4'b0010,13'h400,2'd0);
        for (int i = 0; i < 5; i++)
            add(1,0,1,4'b0001,4'b0001,4'h0,4,NOP,13'h400, 0,4'b0000, 4'b0001,13'h400,2'd0);
        add(1,0,0,NOP,4'b0001,4'h0,4,NOP,13'h400,    0,4'b0000, NOP,13'h400,2'd0);
        add(1,0,0,NOP,4'b0001,4'h0,4,NOP,'0,         0,4'b0001, NOP,13'h400,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,0,4'b0011,13'h055,   0,4'b0000, 4'b0011,13'h055,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h055,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h055,2'd0);
        // Refresh and bank request rising together: refresh first
        add(1,1,0,NOP,4'b0001,4'h0,4,NOP,'0,         1,4'b0000, NOP,13'h055,2'd0);
        add(1,0,1,4'b0001,4'b0001,4'h0,4,NOP,13'h400, 0,4'b0000, 4'b0001,13'h400,2'd0);
        add(1,0,0,NOP,4'b0001,4'h0,4,NOP,13'h400,    0,4'b0000, NOP,13'h400,2'd0);
        add(1,0,0,NOP,4'b0001,4'h0,4,NOP,'0,         0,4'b0001, NOP,13'h400,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,0,4'b0100,13'h066,   0,4'b0000, 4'b0100,13'h066,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h066,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,13'h066,2'd0);
        // Reset during an owned cycle abandons the grant
        add(1,0,0,NOP,4'b0010,4'h0,4,NOP,'0,         0,4'b0010, NOP,13'h066,2'd0);
        add(0,0,0,NOP,4'h0,4'h0,1,4'b0011,13'h077,   0,4'b0000, NOP,'0,2'd0);
        add(1,0,0,NOP,4'h0,4'h0,4,NOP,'0,            0,4'b0000, NOP,'0,2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_rfsh_bg", i), 32'(bus.rfsh_bg), 32'(vecs[i].e_rbg));
            chk($sformatf("v%0d_bank_bg", i), 32'(bus.bank_bg), 32'(vecs[i].e_bbg));
            if (sb.size() > 0) begin
                p = sb.pop_front();
                chk($sformatf("v%0d_pins", i), 32'({bus.sdram_cmd, bus.sdram_a, bus.sdram_ba}),
                    32'({p.cmd, p.a, p.ba}));
            end
            sb.push_back('{cmd: vecs[i].e_cmd, a: vecs[i].e_a, ba: vecs[i].e_ba});
        end
        // Drain the last pin expectation
        @(posedge clk); #1;
        idle_vec(v);
        drive(v);
        @(negedge clk);
        p = sb.pop_front();
        chk("flush_pins", 32'({bus.sdram_cmd, bus.sdram_a, bus.sdram_ba}), 32'({p.cmd, p.a, p.ba}));

        // Refresh blocked by all-busy banks with every bank requesting
        bus.rfsh_br   = 1'b1;
        bus.bank_br   = 4'hF;
        bus.bank_busy = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("blocked_bg", 32'({bus.rfsh_bg, bus.bank_bg}), 32'h0);
            @(posedge clk); #1;
        end
        bus.bank_busy = 4'h0;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (bus.rfsh_bg) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rfsh_wait_bg", 32'(got), 32'd1);
        chk("rfsh_wait_no_bank", 32'(bus.bank_bg), 32'h0);
        @(posedge clk); #1;
        bus.rfsh_br  = 1'b0;
        bus.rfshing  = 1'b1;
        bus.rfsh_cmd = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rfshing_no_bank", 32'(bus.bank_bg), 32'h0);
            @(posedge clk); #1;
        end
        bus.rfshing  = 1'b0;
        bus.rfsh_cmd = NOP;
        @(negedge clk);
        chk("rfsh_tail_no_bank", 32'(bus.bank_bg), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_rfsh_bank0", 32'(bus.bank_bg), 32'h1);
        @(posedge clk); #1;
        bus.bank_br = 4'h0;
        repeat (3) @(posedge clk);
        #1;

`ifdef JTFRAME_SDRAM64_ARB_CHECK_EN
        @(negedge clk);
        chk("bus_err_clean", 32'(bus.bus_err), 32'd0);
        @(posedge clk); #1;
        bus.bank_cmd[15:12] = 4'b0101;
        @(posedge clk); #1;
        bus.bank_cmd[15:12] = NOP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bus_err_sticky", 32'(bus.bus_err), 32'd1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("bus_err_reset", 32'(bus.bus_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
